// File: rtl/tag_dispatch_ddf.sv
// Splits one tagged token stream into per-flux header (NDA) and round-robin body channels.
// Each flux keeps its own header/body state, so tokens from different fluxes may interleave.
module tag_dispatch_ddf #(
    parameter int PORTS = 2,
    parameter int FLUX  = 2,
    parameter int WIDTH = 8
) (
    input  logic                     ck,
    input  logic                     rst_n,
    input  logic                     in0_empty,
    output logic                     in0_read,
    input  logic [WIDTH-1:0]         in0_data,
    input  logic [FLUX-1:0]          nda_full,
    output logic [FLUX-1:0]          nda_wr,
    output logic [WIDTH-$clog2(FLUX)-1:0] nda_data,
    input  logic [PORTS*FLUX-1:0]    out_full,
    output logic [PORTS*FLUX-1:0]    out_wr,
    output logic [WIDTH-$clog2(FLUX)-1:0] out_data,
    output logic                     drop_pulse
);
    localparam int TAG_WIDTH = $clog2(FLUX);
    localparam int PW        = WIDTH - TAG_WIDTH;
    localparam int PTR_W     = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic {HDR = 1'b0, BODY = 1'b1} flux_st_e;

    // Per-flux FSM state, kept as one struct per flux for easy observation.
    typedef struct packed {
        flux_st_e         st;
        logic [PW-1:0]    cnt;
        logic [PTR_W-1:0] ptr;
    } flux_state_t;

    flux_state_t fs_q [FLUX];
    flux_state_t cur;

    logic [TAG_WIDTH-1:0]  tag;
    logic [PW-1:0]         pl;
    logic [FLUX-1:0]       tag_oh;
    logic [PORTS*FLUX-1:0] port_hit;
    logic                  tag_ok;
    logic                  blocked;
    logic                  rd;

    assign tag = in0_data[WIDTH-1:PW];
    assign pl  = in0_data[PW-1:0];

    for (genvar f = 0; f < FLUX; f++) begin : g_flux
        assign tag_oh[f] = (tag == TAG_WIDTH'(f));
        for (genvar p = 0; p < PORTS; p++) begin : g_port
            assign port_hit[p + f*PORTS] = tag_oh[f] & (cur.ptr == PTR_W'(p));
        end
    end

    assign tag_ok = |tag_oh;

    always_comb begin
        cur = '{HDR, '0, '0};
        for (int f = 0; f < FLUX; f++) begin
            if (tag_oh[f]) cur = fs_q[f];
        end
    end

    // Handshake: a token is popped on every ck edge where in0_read=1; in0_read is high
    // only when the input is non-empty and the head token's destination is not full, and
    // every write strobe (nda_wr/out_wr) is asserted only in a cycle where in0_read=1.
    always_comb begin
        blocked = 1'b0;
        if (tag_ok) begin
            if (cur.st == HDR) blocked = |(tag_oh & nda_full);
            else               blocked = |(port_hit & out_full);
        end
    end

    assign rd       = rst_n & ~in0_empty & ~blocked;
    assign in0_read = rd;
    assign nda_wr   = (rd && tag_ok && cur.st == HDR)  ? tag_oh   : '0;
    assign out_wr   = (rd && tag_ok && cur.st == BODY) ? port_hit : '0;
    assign nda_data = pl;
    assign out_data = pl;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse <= 1'b0;
            for (int f = 0; f < FLUX; f++) begin
                fs_q[f] <= '{HDR, '0, '0};
            end
        end else begin
            drop_pulse <= rd & ~tag_ok;
            for (int f = 0; f < FLUX; f++) begin
                if (rd && tag_oh[f]) begin
                    if (fs_q[f].st == HDR) begin
                        // A zero-count header is forwarded but leaves the flux in HDR.
                        if (pl != '0) begin
                            fs_q[f].st  <= BODY;
                            fs_q[f].cnt <= pl;
                            fs_q[f].ptr <= '0;
                        end
                    end else begin
                        fs_q[f].cnt <= fs_q[f].cnt - 1'b1;
                        if (fs_q[f].cnt == PW'(1)) begin
                            fs_q[f].st  <= HDR;
                            fs_q[f].ptr <= '0;
                        end else if (fs_q[f].ptr == PTR_W'(PORTS - 1)) begin
                            fs_q[f].ptr <= '0;
                        end else begin
                            fs_q[f].ptr <= fs_q[f].ptr + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
